bouncing_box_renderer: RTL and testbench

- Pixel-colour stage that sits directly downstream of the VGA sync/counter block.
- Consumes the 640x480 timing (horizontal/vertical counts, HS, VS) and produces registered 12-bit RGB with re-aligned HS/VS for the board connector.
- Renders a solid square over a background colour.
- The square advances once per frame and bounces off the four edges of the active area, under control of a direction state machine.

---
 rtl/bouncing_box_renderer.sv | 144 ++++++++++++++
 tb/tb_bouncing_box_renderer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bouncing_box_renderer.sv
// Pixel-colour stage that follows the VGA sync block. It draws a solid square
// over a background colour, and the square bounces once per frame off the edges of the active area.
module bouncing_box_renderer #(
    parameter int unsigned H_MAX       = 798,
    parameter int unsigned V_MAX       = 523,
    parameter int unsigned H_ACT_START = 144,
    parameter int unsigned V_ACT_START = 35,
    parameter int unsigned H_ACT       = 640,
    parameter int unsigned V_ACT       = 480,
    parameter int unsigned BOX_SIZE    = 32,
    parameter int unsigned STEP        = 2,
    parameter logic [11:0] BOX_RGB     = 12'hFFF,
    parameter logic [11:0] BG_RGB      = 12'h00F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    input  logic       hs_in,
    input  logic       vs_in,
    output logic       hs_out,
    output logic       vs_out,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       frame_tick
);

    localparam logic [9:0]  H_MAX_C   = 10'(H_MAX);
    localparam logic [9:0]  V_MAX_C   = 10'(V_MAX);
    localparam logic [9:0]  H_FIRST   = 10'(H_ACT_START);
    localparam logic [9:0]  V_FIRST   = 10'(V_ACT_START);
    localparam logic [9:0]  H_LAST    = 10'(H_ACT_START + H_ACT - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_ACT_START + V_ACT - 1);
    localparam logic [9:0]  STEP_C    = 10'(STEP);
    localparam logic [10:0] STEP_W    = 11'(STEP);
    localparam logic [10:0] SIZE_W    = 11'(BOX_SIZE);
    localparam logic [9:0]  X_LIMIT   = 10'(H_ACT - BOX_SIZE);
    localparam logic [9:0]  Y_LIMIT   = 10'(V_ACT - BOX_SIZE);

    typedef enum logic {DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1} dir_x_e;
    typedef enum logic {DIR_DOWN  = 1'b0, DIR_UP   = 1'b1} dir_y_e;

    logic [9:0]  box_x_q, box_x_d;
    logic [9:0]  box_y_q, box_y_d;
    dir_x_e      dir_x_q, dir_x_d;
    dir_y_e      dir_y_q, dir_y_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hs_q, vs_q, frame_tick_q;

    logic        end_of_frame;
    logic        active;
    logic        in_box;
    logic [9:0]  px, py;

    always_comb begin
        end_of_frame = (h_count == H_MAX_C) && (v_count == V_MAX_C);
        active = (h_count >= H_FIRST) && (h_count <= H_LAST) &&
                 (v_count >= V_FIRST) && (v_count <= V_LAST);
        px = h_count - H_FIRST;
        py = v_count - V_FIRST;
        // Widened by one bit so box + BOX_SIZE cannot wrap near the far edges.
        in_box = active &&
                 ({1'b0, px} >= {1'b0, box_x_q}) && ({1'b0, px} < {1'b0, box_x_q} + SIZE_W) &&
                 ({1'b0, py} >= {1'b0, box_y_q}) && ({1'b0, py} < {1'b0, box_y_q} + SIZE_W);

        if (in_box) begin
            rgb_d = BOX_RGB;
        end else if (active) begin
            rgb_d = BG_RGB;
        end else begin
            rgb_d = 12'h000;
        end
    end

    // Position only moves during vertical blanking, so a frame never shows two box positions.
    always_comb begin
        box_x_d = box_x_q;
        dir_x_d = dir_x_q;
        box_y_d = box_y_q;
        dir_y_d = dir_y_q;
        if (end_of_frame && en) begin
            if (dir_x_q == DIR_RIGHT) begin
                if ({1'b0, box_x_q} + STEP_W >= {1'b0, X_LIMIT}) begin
                    box_x_d = X_LIMIT;
                    dir_x_d = DIR_LEFT;
                end else begin
                    box_x_d = box_x_q + STEP_C;
                end
            end else if (box_x_q <= STEP_C) begin
                box_x_d = '0;
                dir_x_d = DIR_RIGHT;
            end else begin
                box_x_d = box_x_q - STEP_C;
            end

            if (dir_y_q == DIR_DOWN) begin
                if ({1'b0, box_y_q} + STEP_W >= {1'b0, Y_LIMIT}) begin
                    box_y_d = Y_LIMIT;
                    dir_y_d = DIR_UP;
                end else begin
                    box_y_d = box_y_q + STEP_C;
                end
            end else if (box_y_q <= STEP_C) begin
                box_y_d = '0;
                dir_y_d = DIR_DOWN;
            end else begin
                box_y_d = box_y_q - STEP_C;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            box_x_q      <= '0;
            box_y_q      <= '0;
            dir_x_q      <= DIR_RIGHT;
            dir_y_q      <= DIR_DOWN;
            rgb_q        <= '0;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            box_x_q      <= box_x_d;
            box_y_q      <= box_y_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
            rgb_q        <= rgb_d;
            hs_q         <= hs_in;
            vs_q         <= vs_in;
            frame_tick_q <= end_of_frame;
        end
    end

    assign red        = rgb_q[11:8];
    assign green      = rgb_q[7:4];
    assign blue       = rgb_q[3:0];
    assign hs_out     = hs_q;
    assign vs_out     = vs_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_bouncing_box_renderer.sv
// Randomised bench for bouncing_box_renderer. A position/velocity model predicts
// every registered output, and literal checkpoints pin the bounce trajectory.
module tb_bouncing_box_renderer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       hs_in;
    logic       vs_in;
    logic       hs_out;
    logic       vs_out;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the square: position plus a signed velocity direction.
    int m_x  = 0;
    int m_y  = 0;
    int m_dx = 1;
    int m_dy = 1;
    logic [14:0] exp_out = '0;
    logic        exp_valid = 1'b0;

    bouncing_box_renderer dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .h_count    (h_count),
        .v_count    (v_count),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .hs_out     (hs_out),
        .vs_out     (vs_out),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [11:0] pixel_colour(input int h, input int v, input int bx, input int by);
        int  px, py;
        bit  act;
        px  = h - 144;
        py  = v - 35;
        act = (px >= 0) && (px < 640) && (py >= 0) && (py < 480);
        if (act && px >= bx && px < bx + 32 && py >= by && py < by + 32) return 12'hFFF;
        if (act) return 12'h00F;
        return 12'h000;
    endfunction

    always @(posedge clk) begin
        int nx, ny, ndx, ndy;
        bit eof;
        eof = (int'(h_count) == 798) && (int'(v_count) == 523);
        exp_valid <= 1'b1;
        if (!rst) begin
            exp_out <= '0;
            m_x <= 0; m_y <= 0; m_dx <= 1; m_dy <= 1;
        end else begin
            exp_out <= {hs_in, vs_in, eof, pixel_colour(int'(h_count), int'(v_count), m_x, m_y)};
            if (eof && en) begin
                nx = m_x + 2 * m_dx; ndx = m_dx;
                ny = m_y + 2 * m_dy; ndy = m_dy;
                if (nx >= 608) begin nx = 608; ndx = -1; end
                else if (nx <= 0) begin nx = 0; ndx = 1; end
                if (ny >= 448) begin ny = 448; ndy = -1; end
                else if (ny <= 0) begin ny = 0; ndy = 1; end
                m_x <= nx; m_dx <= ndx;
                m_y <= ny; m_dy <= ndy;
            end
        end
    end

    always @(negedge clk) begin
        if (exp_valid) begin
            check("outputs", int'({hs_out, vs_out, frame_tick, red, green, blue}), int'(exp_out));
        end
    end

    // Applies one set of inputs and returns at the negedge after they were sampled.
    task automatic drive(input int h, input int v, input bit hs, input bit vs);
        h_count = 10'(h);
        v_count = 10'(v);
        hs_in   = hs;
        vs_in   = vs;
        @(negedge clk);
    endtask

    task automatic probe(input int h, input int v, input int exp_rgb, input string name);
        drive(h, v, 1'b0, 1'b0);
        check(name, int'({red, green, blue}), exp_rgb);
    endtask

    task automatic random_pixel();
        int h, v, offs[5];
        offs = '{-1, 0, 31, 32, 0};
        offs[4] = int'($urandom_range(1, 30));
        if ($urandom_range(0, 3) == 0) begin
            h = int'($urandom_range(0, 797));
            v = int'($urandom_range(0, 523));
        end else begin
            h = 144 + m_x + offs[$urandom_range(0, 4)];
            v = 35 + m_y + offs[$urandom_range(0, 4)];
        end
        drive(h, v, 1'($urandom), 1'($urandom));
    endtask

    task automatic run_frames(input int n);
        for (int f = 0; f < n; f++) begin
            for (int i = 0; i < 12; i++) random_pixel();
            drive(798, 523, 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        int hold_x, hold_y;
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(int'($urandom_range(0, 798)), int'($urandom_range(0, 523)), 1'b1, 1'b1);
            check("reset_outputs", int'({hs_out, vs_out, frame_tick, red, green, blue}), 0);
        end
        rst = 1'b1;

        drive(144, 35, 1'b1, 1'b0);
        check("align_box_rgb", int'({red, green, blue}), 12'hFFF);
        check("align_hs", int'(hs_out), 1);
        probe(176, 35, 12'h00F, "align_bg");
        probe(100, 35, 12'h000, "align_blank");
        probe(175, 66, 12'hFFF, "box_far_corner");

        run_frames(10);
        check("model_x_f10", m_x, 20);
        check("model_y_f10", m_y, 20);
        probe(164, 55, 12'hFFF, "box_at_20_20");
        probe(163, 54, 12'h00F, "bg_at_19_19");

        run_frames(214);
        check("model_y_f224", m_y, 448);
        check("model_dy_f224", m_dy, -1);
        check("model_x_f224", m_x, 448);
        probe(144 + 448, 35 + 479, 12'hFFF, "box_bottom_row");

        run_frames(80);
        check("model_x_f304", m_x, 608);
        check("model_dx_f304", m_dx, -1);
        probe(144 + 639, 35 + m_y, 12'hFFF, "box_right_col");

        run_frames(1);
        check("model_x_f305", m_x, 606);
        check("model_y_f305", m_y, 286);
        probe(144 + 606, 35 + 286, 12'hFFF, "box_f305");
        probe(144 + 605, 35 + 286, 12'h00F, "bg_f305");

        run_frames(303);
        check("model_x_f608", m_x, 0);
        check("model_dx_f608", m_dx, 1);
        check("model_y_f608", m_y, 320);
        probe(144, 35 + 320, 12'hFFF, "box_left_edge");
        run_frames(1);
        check("model_x_f609", m_x, 2);
        probe(145, 35 + 322, 12'h00F, "bg_after_left");

        en = 1'b0;
        hold_x = m_x;
        hold_y = m_y;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 6; k++) random_pixel();
            drive(798, 523, 1'b0, 1'b1);
            check("hold_tick", int'(frame_tick), 1);
        end
        check("hold_x", m_x, hold_x);
        check("hold_y", m_y, hold_y);
        probe(144 + 2, 35 + 322, 12'hFFF, "hold_box");
        en = 1'b1;
        run_frames(3);

        drive(300, 100, 1'b1, 1'b1);
        rst = 1'b0;
        drive(301, 100, 1'b1, 1'b1);
        check("midline_reset", int'({hs_out, vs_out, frame_tick, red, green, blue}), 0);
        rst = 1'b1;
        probe(144, 35, 12'hFFF, "post_reset_origin");
        probe(144 + 32, 35, 12'h00F, "post_reset_bg");
        check("post_reset_model_x", m_x, 0);
        run_frames(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
